alphabet_ps2_tx: RTL and testbench
==================================

ALPHABET_PS2_TX -- requirements
Module: alphabet_ps2_tx

Interface
REQ-001 SHALL have parameter HALF_PERIOD, default 4000, clk cycles per PS/2 clock half-period (12.5 kHz at 100 MHz).
REQ-002 SHALL have parameter GAP_CYCLES, default 8000, idle clk cycles between consecutive bytes of one key event.
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  one-cycle request to send one key press/release event.
REQ-006 SHALL have port key_alphabet  input  5  letter index, 1=A ... 26=Z; sampled only on an accepted start.
REQ-007 SHALL have port ps2_clk  output  1  PS/2 clock line driven as device, idle 1.
REQ-008 SHALL have port ps2_data  output  1  PS/2 data line driven as device, idle 1.
REQ-009 SHALL have port busy  output  1  high from the cycle after an accepted start until done.
REQ-010 SHALL have port done  output  1  one-cycle pulse when the event completes.
REQ-011 SHALL have port err  output  1  one-cycle pulse when start carries an invalid index.

Function
REQ-012 SHALL encode index to Set-2 make code: A1C B32 C21 D23 E24 F2B G34 H33 I43 J3B K42 L4B M3A N31 O44 P4D Q15 R2D S1B T2C U3C V2A W1D X22 Y35 Z1A (hex).
REQ-013 SHALL accept start only in IDLE; start while busy, or coincident with done, is ignored.
REQ-014 SHALL, on start with index 0 or 27-31, stay in IDLE, send nothing, pulse err the next cycle, busy stays 0.
REQ-015 SHALL, on a valid start, register the make code and send three bytes in order: make code, F0, make code.
REQ-016 SHALL frame each byte as 11 bits: start 0, data bits 0-7 LSB first, odd parity (total ones incl. parity odd), stop 1.
REQ-017 SHALL give each bit 2*HALF_PERIOD cycles: ps2_data updated on the first cycle, ps2_clk 1 for HALF_PERIOD cycles then 0 for HALF_PERIOD cycles.
REQ-018 SHALL hold ps2_clk=1 and ps2_data=1 during GAP_CYCLES after bytes 1 and 2, and in IDLE.
REQ-019 SHALL use FSM states IDLE, SEND, GAP, FIN: IDLE->SEND on valid start; SEND->GAP after bit 10 of bytes 1-2; GAP->SEND after GAP_CYCLES; SEND->FIN after bit 10 of byte 3; FIN->IDLE after one cycle.
REQ-020 SHALL assert done in the FIN cycle and drop busy the same cycle; a new start is accepted the following cycle.
REQ-021 SHALL take exactly 66*HALF_PERIOD + 2*GAP_CYCLES cycles from the first SEND cycle to the FIN cycle.
REQ-022 SHALL size the half-period and gap counters to hold the larger parameter without wrap; the bit counter counts 0-10, the byte counter 0-2.
REQ-023 SHALL keep key_alphabet changes during busy from affecting the event in progress.

Reset
REQ-024 SHALL, while rst is high, force state IDLE, ps2_clk=1, ps2_data=1, busy=0, done=0, err=0, all counters 0.
REQ-025 SHALL, on rst asserted mid-frame, abort at the next rising edge with no further bits and no done pulse.
REQ-026 SHALL give rst priority over a coincident start.

Verification (HALF_PERIOD=4, GAP_CYCLES=10)
REQ-027 SHALL check start with key_alphabet=1 -> bytes sampled on ps2_clk falls: 1C (bits 0,0,1,1,1,0,0,0, parity 0), F0 (parity 1), 1C; done 284 cycles after first SEND cycle.
REQ-028 SHALL check key_alphabet=26 -> bytes 1A (parity 0), F0, 1A; each ps2_clk low phase exactly 4 cycles, gaps exactly 10 cycles high/high.
REQ-029 SHALL check key_alphabet=0 and 27 -> err pulse 1 cycle, busy 0, ps2_clk/ps2_data stay 1.
REQ-030 SHALL check second start with key_alphabet=2 mid-event -> ignored; event for original letter completes unchanged; next start after done sends 32, F0, 32.
REQ-031 SHALL check rst asserted during bit 5 of byte 2 -> next cycle ps2_clk=1, ps2_data=1, busy=0, no done; fresh start then sends full correct event.

Source files
------------

// File: rtl/alphabet_ps2_tx.sv
// PS/2 device-side transmitter. It sends one key press/release event for a
// letter: the Set-2 make code, then F0, then the make code again. Each byte is
// an 11-bit frame with odd parity, and the bytes are separated by idle gaps.
module alphabet_ps2_tx #(
    parameter int unsigned HALF_PERIOD = 4000,
    parameter int unsigned GAP_CYCLES  = 8000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [4:0] key_alphabet,
    output logic       ps2_clk,
    output logic       ps2_data,
    output logic       busy,
    output logic       done,
    output logic       err
);

    // One counter serves both the half-period and the inter-byte gap, so it
    // is sized for whichever of the two is larger.
    localparam int unsigned MAX_CNT = (HALF_PERIOD > GAP_CYCLES) ? HALF_PERIOD : GAP_CYCLES;
    localparam int unsigned CW      = $clog2(MAX_CNT + 1);
    localparam logic [CW-1:0] HP_LAST  = CW'(HALF_PERIOD - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SEND, GAP, FIN} state_t;

    state_t          r_state, w_state_nxt;
    logic [7:0]      r_code,  w_code_nxt;
    logic [CW-1:0]   r_cnt,   w_cnt_nxt;
    logic            r_half,  w_half_nxt;   // 0: ps2_clk high phase, 1: low phase
    logic [3:0]      r_bit,   w_bit_nxt;    // 0..10 within the frame
    logic [1:0]      r_byte,  w_byte_nxt;   // 0..2 within the event
    logic            r_err,   w_err_nxt;

    logic            w_valid;
    logic [7:0]      w_byte_val;
    logic [10:0]     w_frame;

    // Set-2 make code for letters A..Z; out-of-range indices are never loaded.
    function automatic logic [7:0] f_make_code(input logic [4:0] idx);
        logic [7:0] code;
        case (idx)
            5'd1:    code = 8'h1C;
            5'd2:    code = 8'h32;
            5'd3:    code = 8'h21;
            5'd4:    code = 8'h23;
            5'd5:    code = 8'h24;
            5'd6:    code = 8'h2B;
            5'd7:    code = 8'h34;
            5'd8:    code = 8'h33;
            5'd9:    code = 8'h43;
            5'd10:   code = 8'h3B;
            5'd11:   code = 8'h42;
            5'd12:   code = 8'h4B;
            5'd13:   code = 8'h3A;
            5'd14:   code = 8'h31;
            5'd15:   code = 8'h44;
            5'd16:   code = 8'h4D;
            5'd17:   code = 8'h15;
            5'd18:   code = 8'h2D;
            5'd19:   code = 8'h1B;
            5'd20:   code = 8'h2C;
            5'd21:   code = 8'h3C;
            5'd22:   code = 8'h2A;
            5'd23:   code = 8'h1D;
            5'd24:   code = 8'h22;
            5'd25:   code = 8'h35;
            5'd26:   code = 8'h1A;
            default: code = 8'h00;
        endcase
        return code;
    endfunction

    assign w_valid    = (key_alphabet != 5'd0) && (key_alphabet <= 5'd26);
    // The middle byte of every event is the break prefix.
    assign w_byte_val = (r_byte == 2'd1) ? 8'hF0 : r_code;
    // The frame is {stop, odd parity, data[7:0], start}, indexed by r_bit.
    assign w_frame    = {1'b1, ~(^w_byte_val), w_byte_val, 1'b0};

    // Outputs are decoded from registered state only.
    assign ps2_clk  = !((r_state == SEND) && r_half);
    assign ps2_data = (r_state == SEND) ? w_frame[r_bit] : 1'b1;
    assign busy     = (r_state == SEND) || (r_state == GAP);
    assign done     = (r_state == FIN);
    assign err      = r_err;

    // State register and counters, with synchronous reset taking priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_code  <= 8'h00;
            r_cnt   <= '0;
            r_half  <= 1'b0;
            r_bit   <= 4'd0;
            r_byte  <= 2'd0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_code  <= w_code_nxt;
            r_cnt   <= w_cnt_nxt;
            r_half  <= w_half_nxt;
            r_bit   <= w_bit_nxt;
            r_byte  <= w_byte_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // Next-state logic: bit, byte and gap sequencing.
    always_comb begin
        w_state_nxt = r_state;
        w_code_nxt  = r_code;
        w_cnt_nxt   = r_cnt;
        w_half_nxt  = r_half;
        w_bit_nxt   = r_bit;
        w_byte_nxt  = r_byte;
        w_err_nxt   = 1'b0;

        case (r_state)
            IDLE: begin
                if (start) begin
                    if (w_valid) begin
                        w_state_nxt = SEND;
                        w_code_nxt  = f_make_code(key_alphabet);
                        w_cnt_nxt   = '0;
                        w_half_nxt  = 1'b0;
                        w_bit_nxt   = 4'd0;
                        w_byte_nxt  = 2'd0;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            SEND: begin
                if (r_cnt == HP_LAST) begin
                    w_cnt_nxt = '0;
                    if (!r_half) begin
                        w_half_nxt = 1'b1;
                    end else begin
                        w_half_nxt = 1'b0;
                        if (r_bit == 4'd10) begin
                            w_bit_nxt = 4'd0;
                            if (r_byte == 2'd2) begin
                                w_state_nxt = FIN;
                            end else begin
                                w_byte_nxt  = r_byte + 2'd1;
                                w_state_nxt = GAP;
                            end
                        end else begin
                            w_bit_nxt = r_bit + 4'd1;
                        end
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            GAP: begin
                if (r_cnt == GAP_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = SEND;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            FIN: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
                w_half_nxt  = 1'b0;
                w_bit_nxt   = 4'd0;
                w_byte_nxt  = 2'd0;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_alphabet_ps2_tx.sv
// Bench for alphabet_ps2_tx. A table of key events (fixed corner cases plus
// random letters) is run against a cycle-exact waveform model built from the
// framing rules, and the bytes are also decoded from the ps2_clk falling edges.
module tb_alphabet_ps2_tx;

    localparam int HP  = 4;
    localparam int GAP = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [4:0] key_alphabet;
    logic       ps2_clk;
    logic       ps2_data;
    logic       busy;
    logic       done;
    logic       err;

    int checks = 0;
    int errors = 0;

    logic [7:0] lut [0:31];

    typedef struct {
        logic [4:0] key;
        logic       valid;
        logic [7:0] code;
        int         inj;    // cycle of a mid-event second start, -1 for none
        int         abort;  // cycle of a mid-event reset, -1 for none
    } vec_t;

    vec_t vecs [12];

    alphabet_ps2_tx #(
        .HALF_PERIOD (HP),
        .GAP_CYCLES  (GAP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .key_alphabet (key_alphabet),
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic run_event(input logic [4:0] k, input logic exp_valid, input logic [7:0] exp_code,
                             input int inj, input int abort);
        bit         ec [$];
        bit         ed [$];
        bit         cap [$];
        logic [7:0] bytes [3];
        logic [10:0] got;
        logic [10:0] want;
        logic        prev_clk;
        int          mism;
        int          bad;

        start = 1'b1;
        key_alphabet = k;
        tick();
        start = 1'b0;

        if (!exp_valid) begin
            chk("err_pulse", 32'(err), 32'd1);
            chk("err_busy", 32'(busy), 32'd0);
            chk("err_lines", 32'({ps2_clk, ps2_data}), 32'b11);
            tick();
            chk("err_clear", 32'(err), 32'd0);
            chk("err_idle", 32'({busy, ps2_clk, ps2_data}), 32'b011);
            return;
        end

        // Expected waveform: per bit HP cycles high then HP cycles low,
        // GAP idle cycles between bytes.
        bytes[0] = exp_code;
        bytes[1] = 8'hF0;
        bytes[2] = exp_code;
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < 11; i++) begin
                bit v;
                if (i == 0)       v = 1'b0;
                else if (i <= 8)  v = bytes[b][i-1];
                else if (i == 9)  v = ($countones(bytes[b]) % 2 == 0);
                else              v = 1'b1;
                for (int h = 0; h < 2 * HP; h++) begin
                    ec.push_back(h < HP);
                    ed.push_back(v);
                end
            end
            if (b < 2) begin
                for (int g = 0; g < GAP; g++) begin
                    ec.push_back(1'b1);
                    ed.push_back(1'b1);
                end
            end
        end

        mism = 0;
        prev_clk = 1'b1;
        for (int c = 0; c < ec.size(); c++) begin
            if (c == abort) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                chk("rst_abort", 32'({ps2_clk, ps2_data, busy, done}), 32'b1100);
                bad = 0;
                for (int q = 0; q < 300; q++) begin
                    if (done || !ps2_clk || !ps2_data || busy || err) bad++;
                    tick();
                end
                chk("rst_quiet", 32'(bad), 32'd0);
                return;
            end
            if (ps2_clk !== ec[c] || ps2_data !== ed[c] || busy !== 1'b1 || done !== 1'b0 ||
                err !== 1'b0) begin
                if (mism == 0) $display("first wave deviation at cycle %0d", c);
                mism++;
            end
            if (prev_clk && !ps2_clk) cap.push_back(ps2_data);
            prev_clk = ps2_clk;
            start = (c == inj);
            key_alphabet = (c == inj) ? 5'd2 : 5'($urandom);
            tick();
        end
        start = 1'b0;

        chk("wave", 32'(mism), 32'd0);
        chk("nbits", 32'(cap.size()), 32'd33);
        if (cap.size() == 33) begin
            for (int b = 0; b < 3; b++) begin
                want = {1'b1, ($countones(bytes[b]) % 2 == 0), bytes[b], 1'b0};
                for (int i = 0; i < 11; i++) got[i] = cap[b*11 + i];
                chk($sformatf("frame%0d", b), 32'(got), 32'(want));
            end
        end
        // 66*HP + 2*GAP cycles after the first SEND cycle: the FIN cycle.
        chk("done_timing", 32'({done, busy}), 32'b10);
        start = 1'b1;
        key_alphabet = 5'd3;
        tick();
        start = 1'b0;
        chk("post_fin", 32'({done, busy, ps2_clk, ps2_data}), 32'b0011);
        tick();
        chk("fin_start_ignored", 32'(busy), 32'd0);
    endtask

    initial begin
        lut = '{8'h00, 8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
                8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44,
                8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D,
                8'h22, 8'h35, 8'h1A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

        vecs[0] = '{5'd1,  1'b1, 8'h1C, -1, -1};
        vecs[1] = '{5'd26, 1'b1, 8'h1A, -1, -1};
        vecs[2] = '{5'd0,  1'b0, 8'h00, -1, -1};
        vecs[3] = '{5'd27, 1'b0, 8'h00, -1, -1};
        vecs[4] = '{5'd1,  1'b1, 8'h1C, 60, -1};
        vecs[5] = '{5'd2,  1'b1, 8'h32, -1, -1};
        vecs[6] = '{5'd3,  1'b1, 8'h21, -1, 140};  // byte 2, bit 5
        vecs[7] = '{5'd1,  1'b1, 8'h1C, -1, -1};
        for (int i = 8; i < 12; i++) begin
            logic [4:0] k;
            k = 5'($urandom_range(0, 31));
            vecs[i] = '{k, (k >= 5'd1 && k <= 5'd26), lut[k], -1, -1};
        end

        // Reset with a coincident start: reset wins.
        rst = 1'b1;
        start = 1'b1;
        key_alphabet = 5'd1;
        tick();
        tick();
        chk("reset_state", 32'({ps2_clk, ps2_data, busy, done, err}), 32'b11000);
        rst = 1'b0;
        start = 1'b0;
        tick();
        chk("reset_idle", 32'({ps2_clk, ps2_data, busy, done, err}), 32'b11000);

        for (int i = 0; i < 12; i++) begin
            run_event(vecs[i].key, vecs[i].valid, vecs[i].code, vecs[i].inj, vecs[i].abort);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
